// File: rtl/rgbw_frame_decoder.sv
// Decodes SPI byte frames (cmd, payload, XOR checksum) into committed RGBW
// colour and intensity registers; rejected or aborted frames are counted.
module rgbw_frame_decoder #(
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             rdy,
  input  logic [7:0]       data,
  output logic [7:0]       red,
  output logic [7:0]       green,
  output logic [7:0]       blue,
  output logic [7:0]       white,
  output logic [7:0]       intensity,
  output logic             upd,
  output logic             busy,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CSUM, S_DRAIN} state_t;

  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  state_t           state_q, state_d;
  logic             rdy_q;
  logic [3:0]       op_q, op_d;
  logic [7:0]       acc_q, acc_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0][7:0]  shadow_q, shadow_d;
  logic [7:0]       red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [7:0]       white_q, white_d, int_q, int_d;
  logic             upd_q, upd_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             bev, err_inc;
  logic [3:0]       cmd_info, cur_info;

  // {known, payload length} for an opcode
  function automatic logic [3:0] op_info(input logic [3:0] op);
    case (op)
      4'h1:    op_info = {1'b1, 3'd4};
      4'h2:    op_info = {1'b1, 3'd1};
      4'h3:    op_info = {1'b1, 3'd0};
      default: op_info = {1'b0, 3'd0};
    endcase
  endfunction

  assign bev      = rdy & ~rdy_q & ~cs;
  assign cmd_info = op_info(data[7:4]);
  assign cur_info = op_info(op_q);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    red_d    = red_q;
    green_d  = green_q;
    blue_d   = blue_q;
    white_d  = white_q;
    int_d    = int_q;
    upd_d    = 1'b0;
    err_inc  = 1'b0;

    if (cs) begin
      state_d = S_IDLE;
      err_inc = (state_q == S_PAYLOAD) || (state_q == S_CSUM);
    end else if (bev) begin
      case (state_q)
        S_IDLE: begin
          op_d  = data[7:4];
          acc_d = data;
          idx_d = '0;
          if (!cmd_info[3]) begin
            err_inc = 1'b1;
            state_d = S_DRAIN;
          end else if (cmd_info[2:0] == 3'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          shadow_d[idx_q[1:0]] = data;
          acc_d = acc_q ^ data;
          idx_d = idx_q + 3'd1;
          if (idx_q + 3'd1 == cur_info[2:0]) state_d = S_CSUM;
        end
        S_CSUM: begin
          state_d = S_DRAIN;
          if (data == acc_q) begin
            upd_d = 1'b1;
            case (op_q)
              4'h1: begin
                red_d   = shadow_q[0];
                green_d = shadow_q[1];
                blue_d  = shadow_q[2];
                white_d = shadow_q[3];
              end
              4'h2: int_d = shadow_q[0];
              default: begin
                red_d   = '0;
                green_d = '0;
                blue_d  = '0;
                white_d = '0;
              end
            endcase
          end else begin
            err_inc = 1'b1;
          end
        end
        default: ;
      endcase
    end

    err_d = (err_inc && (err_q != '1)) ? err_q + ERR_ONE : err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rdy_q    <= 1'b0;
      op_q     <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
      white_q  <= '0;
      int_q    <= '1;
      upd_q    <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= rdy;
      op_q     <= op_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
      white_q  <= white_d;
      int_q    <= int_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
    end
  end

  assign red       = red_q;
  assign green     = green_q;
  assign blue      = blue_q;
  assign white     = white_q;
  assign intensity = int_q;
  assign upd       = upd_q;
  assign busy      = (state_q != S_IDLE);
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_rgbw_frame_decoder.sv
// Self-checking bench for rgbw_frame_decoder: directed frames plus random
// frames compared against a frame-level reference model.
module tb_rgbw_frame_decoder;

  typedef logic [7:0] bq_t [$];

  logic       clk = 1'b0;
  logic       reset, cs, rdy;
  logic [7:0] data;
  logic [7:0] red, green, blue, white, intensity;
  logic       upd, busy;
  logic [7:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int upd_cnt = 0;
  bit hold2 = 1'b0;

  // reference model state
  logic [7:0] m_r, m_g, m_b, m_w, m_i;
  int         m_err, m_upd;

  rgbw_frame_decoder #(.ERR_W(8)) dut (
    .clk(clk), .reset(reset), .cs(cs), .rdy(rdy), .data(data),
    .red(red), .green(green), .blue(blue), .white(white),
    .intensity(intensity), .upd(upd), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (upd === 1'b1) upd_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_r = 8'h00; m_g = 8'h00; m_b = 8'h00; m_w = 8'h00; m_i = 8'hFF; m_err = 0;
  endfunction

  function automatic void bump_err();
    if (m_err < 255) m_err++;
  endfunction

  // Frame-level rules: effective bytes seen while cs was low.
  function automatic void model_frame(input bq_t fb, output bit commit, output bit exact);
    logic [7:0] c, x;
    int n;
    commit = 1'b0;
    exact  = 1'b0;
    if (fb.size() == 0) return;
    c = fb[0];
    if (c[7:4] == 4'h1) n = 4;
    else if (c[7:4] == 4'h2) n = 1;
    else if (c[7:4] == 4'h3) n = 0;
    else begin bump_err(); return; end
    if (fb.size() < n + 2) begin bump_err(); return; end
    x = 8'h00;
    for (int i = 0; i <= n; i++) x ^= fb[i];
    if (fb[n+1] != x) begin bump_err(); return; end
    commit = 1'b1;
    exact  = (fb.size() == n + 2);
    m_upd++;
    if (n == 4) begin m_r = fb[1]; m_g = fb[2]; m_b = fb[3]; m_w = fb[4]; end
    else if (n == 1) m_i = fb[1];
    else begin m_r = 8'h00; m_g = 8'h00; m_b = 8'h00; m_w = 8'h00; end
  endfunction

  task automatic chk_outputs(input string pfx);
    chk({pfx, "_red"},   red,       m_r);
    chk({pfx, "_green"}, green,     m_g);
    chk({pfx, "_blue"},  blue,      m_b);
    chk({pfx, "_white"}, white,     m_w);
    chk({pfx, "_int"},   intensity, m_i);
    chk({pfx, "_err"},   err_cnt,   m_err);
    chk({pfx, "_updn"},  upd_cnt,   m_upd);
  endtask

  // cs_on_last: last byte's rdy rises in the same cycle cs goes high
  task automatic send_frame(input bq_t fb, input bit cs_on_last);
    bq_t eff;
    bit commit, exact;
    int unsigned gap;
    eff = fb;
    if (cs_on_last) void'(eff.pop_back());
    model_frame(eff, commit, exact);
    @(negedge clk); cs = 1'b0;
    foreach (fb[i]) begin
      @(negedge clk);
      data = fb[i];
      rdy  = 1'b1;
      if (cs_on_last && i == fb.size() - 1) cs = 1'b1;
      @(negedge clk);
      if (i == fb.size() - 1) chk("upd_latency", upd, !cs_on_last && exact);
      if (hold2 || $urandom_range(0, 1) == 1) @(negedge clk);
      rdy = 1'b0;
      gap = $urandom_range(0, 1);
      repeat (gap) @(negedge clk);
    end
    if (!cs_on_last) chk("busy_pre", busy, fb.size() != 0);
    cs = 1'b1;
    @(negedge clk);
    chk("busy_post", busy, 0);
    @(negedge clk);
    chk_outputs("frm");
  endtask

  initial begin
    bq_t fb;
    logic [7:0] x, b;
    int n, kind, t;
    reset = 1'b1; cs = 1'b1; rdy = 1'b0; data = 8'h00;
    m_upd = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_red", red, 0);
    chk("rst_white", white, 0);
    chk("rst_int", intensity, 8'hFF);
    chk("rst_err", err_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_upd", upd, 0);
    reset = 1'b0;
    @(negedge clk);

    hold2 = 1'b1;
    send_frame('{8'h10, 8'h11, 8'h22, 8'h33, 8'h44, 8'h54}, 1'b0);
    hold2 = 1'b0;
    send_frame('{8'h20, 8'h80, 8'hA5}, 1'b0);
    send_frame('{8'h20, 8'h80, 8'hA0}, 1'b0);
    send_frame('{8'h10, 8'h01, 8'h02}, 1'b0);
    send_frame('{8'h70, 8'h12, 8'h34}, 1'b0);
    send_frame('{8'h30, 8'h30}, 1'b0);
    send_frame('{8'h20, 8'h33, 8'h13}, 1'b1);
    send_frame('{8'h3F, 8'h3F, 8'h99, 8'h98}, 1'b0);

    for (int f = 0; f < 40; f++) begin
      fb.delete();
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin x = {4'h1, 4'($urandom)}; n = 4; end
        1: begin x = {4'h2, 4'($urandom)}; n = 1; end
        2: begin x = {4'h3, 4'($urandom)}; n = 0; end
        default: begin x = {4'($urandom_range(4, 16)), 4'($urandom)}; n = $urandom_range(0, 3); end
      endcase
      fb.push_back(x);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        fb.push_back(b);
        x ^= b;
      end
      if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
      fb.push_back(x);
      if ($urandom_range(0, 4) == 0) begin
        t = $urandom_range(1, fb.size() - 1);
        while (fb.size() > t) void'(fb.pop_back());
      end
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 2)) fb.push_back(8'($urandom));
      send_frame(fb, 1'b0);
    end

    send_frame('{8'h10, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h10}, 1'b0);
    send_frame('{8'h20, 8'h40, 8'h60}, 1'b0);
    for (int f = 0; f < 300; f++) send_frame('{8'h70}, 1'b0);
    chk("err_saturated", err_cnt, 8'hFF);

    // reset in the middle of a colour frame
    @(negedge clk); cs = 1'b0;
    @(negedge clk); data = 8'h10; rdy = 1'b1;
    @(negedge clk); rdy = 1'b0;
    @(negedge clk); data = 8'h55; rdy = 1'b1;
    @(negedge clk); rdy = 1'b0; reset = 1'b1;
    @(negedge clk);
    model_reset();
    chk("midrst_busy", busy, 0);
    chk("midrst_upd", upd, 0);
    chk_outputs("midrst");
    reset = 1'b0; cs = 1'b1;
    @(negedge clk);
    send_frame('{8'h12, 8'h01, 8'h02, 8'h03, 8'h04, 8'h16}, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
